// File: rtl/fp_multicycle_controller.sv
// Multicycle Moore main controller for the RV32IF core, with a bounded handshake to a multi-cycle FPU.
// The FP path (flw/fsw/fcomp decode, FPU states, wait counter, timeout flag) is compiled in only when FP_EXT_EN is defined.
module fp_multicycle_controller #(
    parameter int FPU_TIMEOUT = 32,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OP,
    input  logic [4:0] funct5,
    input  logic       fpu_done,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALU_OP,
    output logic [1:0] IMMSRC,
    output logic [2:0] ResultSrc,
    output logic       REGWRITE,
    output logic       REGWRITE_F,
    output logic       Branch,
    output logic       DATA_MEM_SRC,
    output logic       FPU_OP,
    output logic       fsrc,
    output logic       fpu_start,
    output logic       illegal,
    output logic       fpu_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        FPEXEC   = 4'd11,
        FPWAIT   = 4'd12,
        FPWB     = 4'd13,
        FMOVWB   = 4'd14,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state_r, state_s;
    logic   illegal_r, illegal_s;

    // State register and sticky illegal-opcode flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            illegal_r <= illegal_s;
        end
    end

`ifdef FP_EXT_EN
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_FSW   = 7'b0100111;
    localparam logic [6:0] OP_FP    = 7'b1010011;
    localparam logic [4:0] F5_FMVXW = 5'b11100;
    localparam logic [4:0] F5_FMVWX = 5'b11110;
    localparam logic [4:0] F5_FCVTW = 5'b11000;
    localparam logic [4:0] F5_FCMP  = 5'b10100;
    localparam logic [4:0] F5_FCVTS = 5'b11010;

    logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic             timeout_r, timeout_s;

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // FPU wait counter and sticky timeout flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            timeout_r <= timeout_s;
        end
    end

    assign fpu_timeout = timeout_r;
    assign fsrc        = (funct5 == F5_FCVTS);
`else
    logic unused_s;
    assign unused_s    = ^{fpu_done, funct5, CNT_W'(FPU_TIMEOUT)};
    assign fpu_timeout = 1'b0;
    assign fsrc        = 1'b0;
`endif

    assign illegal = illegal_r;
    assign state   = state_r;

    // Next-state logic; a timeout hit only matters when fpu_done is low in FPWAIT
    always_comb begin
        state_s   = state_r;
        illegal_s = illegal_r;
`ifdef FP_EXT_EN
        cnt_s     = cnt_r;
        timeout_s = timeout_r;
`endif
        case (state_r)
            FETCH:   state_s = DECODE;
            DECODE: begin
                case (OP)
                    OP_LW, OP_SW: state_s = MEMADR;
                    OP_R:         state_s = EXECR;
                    OP_I:         state_s = EXECI;
                    OP_BEQ:       state_s = BEQ;
                    OP_JAL:       state_s = JAL;
`ifdef FP_EXT_EN
                    OP_FLW, OP_FSW: state_s = MEMADR;
                    OP_FP: begin
                        if (funct5 == F5_FMVXW || funct5 == F5_FMVWX) begin
                            state_s = FMOVWB;
                        end else begin
                            state_s = FPEXEC;
                        end
                    end
`endif
                    default: begin
                        state_s   = TRAP;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (OP[5]) begin
                    state_s = MEMWRITE;
                end else begin
                    state_s = MEMREAD;
                end
            end
            MEMREAD:                        state_s = MEMWB;
            EXECR, EXECI:                   state_s = ALUWB;
            MEMWB, MEMWRITE, ALUWB, BEQ, JAL: state_s = FETCH;
`ifdef FP_EXT_EN
            FPEXEC: begin
                state_s = FPWAIT;
                cnt_s   = {CNT_W{1'b0}};
            end
            FPWAIT: begin
                if (fpu_done) begin
                    state_s = FPWB;
                end else begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == CNT_W'(FPU_TIMEOUT)) begin
                        state_s   = TRAP;
                        timeout_s = 1'b1;
                    end else begin
                        state_s = FPWAIT;
                    end
                end
            end
            FPWB, FMOVWB: state_s = FETCH;
`endif
            TRAP:    state_s = TRAP;
            default: begin
                state_s   = TRAP;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Moore output decode of the state register
    always_comb begin
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        MemWrite     = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALU_OP       = 2'b00;
        IMMSRC       = 2'b00;
        ResultSrc    = 3'b000;
        REGWRITE     = 1'b0;
        REGWRITE_F   = 1'b0;
        Branch       = 1'b0;
        DATA_MEM_SRC = 1'b0;
        FPU_OP       = 1'b0;
        fpu_start    = 1'b0;
        case (state_r)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                IMMSRC  = OP[5] ? 2'b01 : 2'b00;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 3'b001;
                REGWRITE  = (OP == OP_LW);
`ifdef FP_EXT_EN
                REGWRITE_F = (OP == OP_FLW);
`endif
            end
            MEMWRITE: begin
                AdrSrc       = 1'b1;
                MemWrite     = 1'b1;
                DATA_MEM_SRC = (OP == OP_SW);
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALU_OP  = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALU_OP  = 2'b10;
            end
            ALUWB: REGWRITE = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                ALU_OP  = 2'b01;
                IMMSRC  = 2'b10;
                Branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                IMMSRC    = 2'b11;
                PCWrite   = 1'b1;
                REGWRITE  = 1'b1;
                ResultSrc = 3'b010;
            end
`ifdef FP_EXT_EN
            FPEXEC: fpu_start = 1'b1;
            FPWB: begin
                ResultSrc = 3'b011;
                FPU_OP    = 1'b1;
                if (funct5 == F5_FCVTW || funct5 == F5_FCMP) begin
                    REGWRITE = 1'b1;
                end else begin
                    REGWRITE_F = 1'b1;
                end
            end
            FMOVWB: begin
                if (funct5 == F5_FMVXW) begin
                    REGWRITE  = 1'b1;
                    ResultSrc = 3'b101;
                end else begin
                    REGWRITE_F = 1'b1;
                    ResultSrc  = 3'b100;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_multicycle_controller.sv
// Randomized bench for fp_multicycle_controller: each instruction is expanded into its expected
// per-cycle trace from the latency/write-back rules, then the DUT is stepped and compared cycle by cycle.
module tb_fp_multicycle_controller;

    localparam int TMO = 4;

`ifdef FP_EXT_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                   S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BEQ = 9,
                   S_JAL = 10, S_FPEXEC = 11, S_FPWAIT = 12, S_FPWB = 13, S_FMOVWB = 14,
                   S_TRAP = 15;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, FLW = 7'b0000111, FSW = 7'b0100111,
                           RT = 7'b0110011, IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                           FC = 7'b1010011;

    // enable vector: {PCWrite, IRWrite, MemWrite, REGWRITE, REGWRITE_F, fpu_start, FPU_OP}
    localparam logic [6:0] E_PC = 7'b1000000, E_IR = 7'b0100000, E_MW = 7'b0010000,
                           E_RW = 7'b0001000, E_RWF = 7'b0000100, E_ST = 7'b0000010,
                           E_FO = 7'b0000001;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] OP;
    logic [4:0] funct5;
    logic       fpu_done;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ALU_OP, IMMSRC;
    logic [2:0] ResultSrc;
    logic       REGWRITE, REGWRITE_F, Branch, DATA_MEM_SRC, FPU_OP, fsrc, fpu_start;
    logic       illegal, fpu_timeout;
    logic [3:0] state;

    fp_multicycle_controller #(.FPU_TIMEOUT(TMO), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .OP(OP), .funct5(funct5), .fpu_done(fpu_done),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_OP(ALU_OP), .IMMSRC(IMMSRC),
        .ResultSrc(ResultSrc), .REGWRITE(REGWRITE), .REGWRITE_F(REGWRITE_F),
        .Branch(Branch), .DATA_MEM_SRC(DATA_MEM_SRC), .FPU_OP(FPU_OP), .fsrc(fsrc),
        .fpu_start(fpu_start), .illegal(illegal), .fpu_timeout(fpu_timeout), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         st;
        logic [6:0] en;
        int         rs;
        bit         chk_rs;
        int         dms;
        bit         chk_dms;
        bit         br;
        bit         ill;
        bit         tmo;
        bit         done;
        bit         rst;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t mk(input int st, input logic [6:0] en);
        exp_t e;
        e.st = st; e.en = en; e.rs = 0; e.chk_rs = 1'b0; e.dms = 0; e.chk_dms = 1'b0;
        e.br = 1'b0; e.ill = 1'b0; e.tmo = 1'b0; e.done = 1'b0; e.rst = 1'b0;
        return e;
    endfunction

    // Expand one instruction into its expected cycle trace
    task automatic build(input logic [6:0] op, input logic [4:0] f5, input int n_done);
        exp_t e;
        bit   trap_i = 1'b0;
        bit   trap_t = 1'b0;
        bit   fin    = 1'b0;
        int   reps;
        q.delete();
        q.push_back(mk(S_FETCH, E_PC | E_IR));
        q.push_back(mk(S_DECODE, 7'd0));
        if (op == LW || (FP && op == FLW)) begin
            q.push_back(mk(S_MEMADR, 7'd0));
            q.push_back(mk(S_MEMREAD, 7'd0));
            e = mk(S_MEMWB, (op == LW) ? E_RW : E_RWF); e.rs = 1; e.chk_rs = 1'b1;
            q.push_back(e);
        end else if (op == SW || (FP && op == FSW)) begin
            q.push_back(mk(S_MEMADR, 7'd0));
            e = mk(S_MEMWRITE, E_MW); e.dms = (op == SW) ? 1 : 0; e.chk_dms = 1'b1;
            q.push_back(e);
        end else if (op == RT || op == IT) begin
            q.push_back(mk((op == RT) ? S_EXECR : S_EXECI, 7'd0));
            e = mk(S_ALUWB, E_RW); e.rs = 0; e.chk_rs = 1'b1;
            q.push_back(e);
        end else if (op == BQ) begin
            e = mk(S_BEQ, 7'd0); e.br = 1'b1;
            q.push_back(e);
        end else if (op == JL) begin
            e = mk(S_JAL, E_PC | E_RW); e.rs = 2; e.chk_rs = 1'b1;
            q.push_back(e);
        end else if (FP && op == FC) begin
            if (f5 == 5'b11100) begin
                e = mk(S_FMOVWB, E_RW); e.rs = 5; e.chk_rs = 1'b1; q.push_back(e);
            end else if (f5 == 5'b11110) begin
                e = mk(S_FMOVWB, E_RWF); e.rs = 4; e.chk_rs = 1'b1; q.push_back(e);
            end else begin
                q.push_back(mk(S_FPEXEC, E_ST));
                for (int k = 1; k <= TMO && !fin; k++) begin
                    e = mk(S_FPWAIT, 7'd0); e.done = (k == n_done); q.push_back(e);
                    if (k == n_done) begin
                        e = mk(S_FPWB, ((f5 == 5'b11000 || f5 == 5'b10100) ? E_RW : E_RWF) | E_FO);
                        e.rs = 3; e.chk_rs = 1'b1; q.push_back(e);
                        fin = 1'b1;
                    end else if (k == TMO) begin
                        trap_t = 1'b1;
                    end
                end
            end
        end else begin
            trap_i = 1'b1;
        end
        if (trap_i || trap_t) begin
            reps = int'($urandom_range(1, 3));
            for (int r = 0; r < reps; r++) begin
                e = mk(S_TRAP, 7'd0); e.ill = trap_i; e.tmo = trap_t; e.rst = (r == reps - 1);
                q.push_back(e);
            end
        end
    endtask

    // Drive one instruction and compare every cycle; rst_at >= 0 cuts it short with a reset
    task automatic run(input logic [6:0] op, input logic [4:0] f5, input int n_done, input int rst_at);
        exp_t e;
        bit   stop = 1'b0;
        build(op, f5, n_done);
        OP = op;
        funct5 = f5;
        for (int i = 0; i < q.size() && !stop; i++) begin
            e = q[i];
            fpu_done = (e.st == S_FPWAIT) ? e.done : 1'($urandom_range(0, 1));
            RST = e.rst || (i == rst_at);
            @(negedge CLK);
            check_val("state", 32'(state), 32'(e.st));
            check_val("wen", 32'({PCWrite, IRWrite, MemWrite, REGWRITE, REGWRITE_F, fpu_start, FPU_OP}), 32'(e.en));
            check_val("branch", 32'(Branch), 32'(e.br));
            check_val("illegal", 32'(illegal), 32'(e.ill));
            check_val("fpu_timeout", 32'(fpu_timeout), 32'(e.tmo));
            check_val("fsrc", 32'(fsrc), 32'(FP && (f5 == 5'b11010)));
            if (e.chk_rs) check_val("resultsrc", 32'(ResultSrc), 32'(e.rs));
            if (e.chk_dms) check_val("data_mem_src", 32'(DATA_MEM_SRC), 32'(e.dms));
            if (e.st == S_FETCH) check_val("alusrcb_fetch", 32'(ALUSrcB), 32'd2);
            @(posedge CLK);
            #1;
            if (i == rst_at) stop = 1'b1;
        end
        RST = 1'b0;
    endtask

    logic [6:0] ops [11];
    logic [4:0] f5s [7];
    logic [6:0] rop;
    logic [4:0] rf5;
    int         rat;

    initial begin
        ops = '{LW, SW, FLW, FSW, RT, IT, BQ, JL, FC, FC, 7'b1111111};
        f5s = '{5'b00000, 5'b11100, 5'b11110, 5'b11000, 5'b10100, 5'b11010, 5'b00011};
        RST = 1'b1;
        OP = 7'd0;
        funct5 = 5'd0;
        fpu_done = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_val("reset_state", 32'(state), 32'(S_FETCH));
        check_val("reset_illegal", 32'(illegal), 32'd0);
        check_val("reset_timeout", 32'(fpu_timeout), 32'd0);

        run(LW, 5'b00000, 0, -1);
        run(FSW, 5'b00000, 0, -1);
        run(FC, 5'b00000, 3, -1);
        run(FC, 5'b11100, 0, -1);
        run(FC, 5'b00000, 99, -1);
        run(7'b1111111, 5'b00000, 0, -1);
        run(LW, 5'b00000, 0, 3);
        run(FC, 5'b11000, TMO, -1);
        run(JL, 5'b11010, 0, -1);

        for (int n = 0; n < 100; n++) begin
            rop = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) rop = 7'($urandom);
            rf5 = f5s[$urandom_range(0, 6)];
            rat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : -1;
            run(rop, rf5, int'($urandom_range(1, TMO + 2)), rat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
